// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle execution controller.
// Holds FSM states, opcode/funct3 fields, the EBREAK word, classes and ALU selects.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT,
    S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    C_ILLEGAL,
    C_RTYPE,
    C_ISHIFT,
    C_JAL,
    C_JALR,
    C_EBREAK
  } iclass_t;

  typedef enum logic [1:0] {
    B_RS2   = 2'b00,
    B_SHAMT = 2'b01,
    B_FOUR  = 2'b10,
    B_ZERO  = 2'b11
  } alub_t;

  localparam logic A_RS1 = 1'b0;
  localparam logic A_PC  = 1'b1;

  localparam logic [6:0] OP_REG  = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

  function automatic logic is_jump(iclass_t c);
    return (c == C_JAL) || (c == C_JALR);
  endfunction

  // Jumps compute the link value pc+4 on the ALU.
  function automatic logic alua_of(iclass_t c);
    return is_jump(c) ? A_PC : A_RS1;
  endfunction

  function automatic logic [1:0] alub_of(iclass_t c);
    logic [1:0] b;
    b = B_RS2;
    if (c == C_ISHIFT) b = B_SHAMT;
    if (is_jump(c))    b = B_FOUR;
    return b;
  endfunction

endpackage

// File: rtl/exec_ctrl_decode.sv
// Combinational instruction classifier: i_inst -> o_class.
// Ports: i_inst (32-bit instruction word), o_class (iclass_t).
module exec_ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] i_inst,
  output iclass_t     o_class
);

  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic       w_shift_f3;

  assign w_op       = i_inst[6:0];
  assign w_f3       = i_inst[14:12];
  assign w_shift_f3 = (w_f3 == F3_SLL) || (w_f3 == F3_SRX);

  // Branches are mutually exclusive: EBREAK's opcode differs from all others.
  always_comb begin
    o_class = C_ILLEGAL;
    unique case (1'b1)
      (i_inst == EBREAK_WORD):        o_class = C_EBREAK;
      (w_op == OP_REG):               o_class = C_RTYPE;
      (w_op == OP_IMM && w_shift_f3): o_class = C_ISHIFT;
      (w_op == OP_JAL):               o_class = C_JAL;
      (w_op == OP_JALR):              o_class = C_JALR;
      default:                        o_class = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/exec_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB controller with HALT and TRAP sinks.
// Ports: clk, rst (sync, active-high), imem_req/imem_ack/inst fetch handshake,
//   ALUAsrc/ALUBsrc selects, ir_we, reg_we, pc_we, pc_sel, halt, illegal.
// Optional: EXEC_CTRL_RETIRE_CNT_EN adds retire_cnt[31:0] counting WB cycles.
module exec_ctrl
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] inst,
  output logic        ALUAsrc,
  output logic [1:0]  ALUBsrc,
  output logic        ir_we,
  output logic        reg_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        halt,
  output logic        illegal
`ifdef EXEC_CTRL_RETIRE_CNT_EN
  ,
  output logic [31:0] retire_cnt
`endif
);

  state_t      r_state;
  iclass_t     r_class;
  iclass_t     w_class;
  logic [31:0] r_ir;
  logic        r_imem_req;
  logic        r_alua;
  logic [1:0]  r_alub;
  logic        r_reg_we;
  logic        r_pc_we;
  logic        r_pc_sel;
  logic        r_halt;
  logic        r_illegal;

  // Local copy of the fetched word so decode never sees a changing bus.
  exec_ctrl_decode u_decode (
    .i_inst  (r_ir),
    .o_class (w_class)
  );

  // Outputs are registered: each transition loads the next state's values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_class    <= C_ILLEGAL;
      r_ir       <= '0;
      r_imem_req <= 1'b0;
      r_alua     <= A_RS1;
      r_alub     <= B_RS2;
      r_reg_we   <= 1'b0;
      r_pc_we    <= 1'b0;
      r_pc_sel   <= 1'b0;
      r_halt     <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_reg_we <= 1'b0;
      r_pc_we  <= 1'b0;
      r_pc_sel <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_state    <= S_FETCH;
          r_imem_req <= 1'b1;
        end
        S_FETCH: begin
          if (imem_ack) begin
            r_ir       <= inst;
            r_imem_req <= 1'b0;
            r_state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_class <= w_class;
          unique case (w_class)
            C_EBREAK: begin
              r_state <= S_HALT;
              r_halt  <= 1'b1;
            end
            C_ILLEGAL: begin
              r_state   <= S_TRAP;
              r_illegal <= 1'b1;
            end
            default: begin
              r_state <= S_EXEC;
              r_alua  <= alua_of(w_class);
              r_alub  <= alub_of(w_class);
            end
          endcase
        end
        S_EXEC: begin
          r_state  <= S_WB;
          r_reg_we <= 1'b1;
          r_pc_we  <= 1'b1;
          r_pc_sel <= is_jump(r_class);
        end
        S_WB: begin
          r_state    <= S_FETCH;
          r_alua     <= A_RS1;
          r_alub     <= B_RS2;
          r_imem_req <= 1'b1;
        end
        S_HALT: r_state <= S_HALT;
        S_TRAP: r_state <= S_TRAP;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // IR write is the only combinational output; rst kills a same-cycle ack.
  assign ir_we = (r_state == S_FETCH) && imem_ack && !rst;

  assign imem_req = r_imem_req;
  assign ALUAsrc  = r_alua;
  assign ALUBsrc  = r_alub;
  assign reg_we   = r_reg_we;
  assign pc_we    = r_pc_we;
  assign pc_sel   = r_pc_sel;
  assign halt     = r_halt;
  assign illegal  = r_illegal;

`ifdef EXEC_CTRL_RETIRE_CNT_EN
  logic [31:0] r_retire_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_retire_cnt <= '0;
    end else if (r_state == S_WB) begin
      r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

  assign retire_cnt = r_retire_cnt;
`endif

endmodule

// File: tb/tb_exec_ctrl.sv
// Scoreboard bench for exec_ctrl: random fetch timing and instruction mix.
// Driver pushes expected retire/halt/trap records; monitor pops on DUT events.
module tb_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] inst;
  logic        ALUAsrc;
  logic [1:0]  ALUBsrc;
  logic        ir_we;
  logic        reg_we;
  logic        pc_we;
  logic        pc_sel;
  logic        halt;
  logic        illegal;
`ifdef EXEC_CTRL_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  always #5 clk = ~clk;

  exec_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .imem_req (imem_req),
    .imem_ack (imem_ack),
    .inst     (inst),
    .ALUAsrc  (ALUAsrc),
    .ALUBsrc  (ALUBsrc),
    .ir_we    (ir_we),
    .reg_we   (reg_we),
    .pc_we    (pc_we),
    .pc_sel   (pc_sel),
    .halt     (halt),
    .illegal  (illegal)
`ifdef EXEC_CTRL_RETIRE_CNT_EN
    ,
    .retire_cnt (retire_cnt)
`endif
  );

  localparam int K_RET  = 0;
  localparam int K_HALT = 1;
  localparam int K_TRAP = 2;

  typedef struct {
    int          kind;
    int unsigned ack_cyc;
    int          req_len;
    logic        a;
    logic [1:0]  b;
    logic        psel;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  logic [31:0] mdl_cnt = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Reference: the instruction rules written directly from the ISA subset.
  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    logic [6:0] op;
    logic [2:0] f3;
    op = w[6:0];
    f3 = w[14:12];
    e.kind = K_TRAP;
    e.a = 1'b0;
    e.b = 2'b00;
    e.psel = 1'b0;
    e.ack_cyc = 0;
    e.req_len = 0;
    if (w == 32'h0010_0073) e.kind = K_HALT;
    else if (op == 7'h33) e.kind = K_RET;
    else if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
      e.kind = K_RET;
      e.b = 2'b01;
    end else if (op == 7'h6F || op == 7'h67) begin
      e.kind = K_RET;
      e.a = 1'b1;
      e.b = 2'b10;
      e.psel = 1'b1;
    end
    return e;
  endfunction

  // ---------------- monitor ----------------
  bit          sticky_h = 0;
  bit          sticky_i = 0;
  bit          prev_rst = 0;
  bit          cnt_next = 0;
  int          req_run = 0;
  int unsigned req_at = 0;
  logic        prev_a = 0;
  logic [1:0]  prev_b = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("ir_we_in_rst", ir_we, 0);
      q.delete();
      sticky_h = 0;
      sticky_i = 0;
      req_run  = 0;
      req_at   = 0;
      cnt_next = 0;
      mdl_cnt  = '0;
      prev_rst = 1;
    end else begin
      if (prev_rst) begin
        chk("outs_after_rst",
            {imem_req, ALUAsrc, ALUBsrc, ir_we, reg_we, pc_we, pc_sel,
             halt, illegal}, 0);
`ifdef EXEC_CTRL_RETIRE_CNT_EN
        chk("cnt_after_rst", retire_cnt, 0);
`endif
        prev_rst = 0;
      end
      chk("ir_we", ir_we, imem_req & imem_ack);
`ifdef EXEC_CTRL_RETIRE_CNT_EN
      if (cnt_next) chk("retire_cnt", retire_cnt, mdl_cnt);
`endif
      cnt_next = 0;
      if (req_at != 0 && cyc == req_at) begin
        chk("req_after_wb", imem_req, 1);
        req_at = 0;
      end
      req_run = imem_req ? req_run + 1 : 0;
      if (imem_req && imem_ack) begin
        if (q.size() == 0) chk("ack_no_record", 1, 0);
        else chk("req_len", req_run, q[$].req_len);
      end
      if (sticky_h || sticky_i) begin
        chk("sticky",
            {halt, illegal, imem_req, ALUAsrc, ALUBsrc, ir_we, reg_we,
             pc_we, pc_sel}, {sticky_h, sticky_i, 8'h00});
      end else if (halt || illegal) begin
        if (q.size() == 0) chk("unexpected_stop", {halt, illegal}, 0);
        else begin
          e = q.pop_front();
          chk("stop_kind", halt ? K_HALT : K_TRAP, e.kind);
          chk("stop_cycle", cyc, e.ack_cyc + 2);
          chk("stop_both", {halt, illegal, reg_we, pc_we},
              {halt, !halt, 2'b00});
          sticky_h = halt;
          sticky_i = illegal;
        end
      end else if (reg_we) begin
        if (q.size() == 0) chk("unexpected_wb", reg_we, 0);
        else begin
          e = q.pop_front();
          chk("wb_kind", e.kind, K_RET);
          chk("wb_cycle", cyc, e.ack_cyc + 3);
          chk("wb_outs", {pc_we, pc_sel, ALUAsrc, ALUBsrc},
              {1'b1, e.psel, e.a, e.b});
          chk("exec_sel", {prev_a, prev_b}, {e.a, e.b});
          mdl_cnt  = mdl_cnt + 1;
          cnt_next = 1;
          req_at   = cyc + 1;
        end
      end else if (!(q.size() > 0 && q[0].kind == K_RET &&
                     cyc == q[0].ack_cyc + 2)) begin
        chk("sel_idle", {ALUAsrc, ALUBsrc, pc_we, pc_sel}, 0);
      end
      prev_a = ALUAsrc;
      prev_b = ALUBsrc;
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_ack = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 0;
    for (int i = 0; i < 64; i++) begin
      if (imem_req) begin
        ok = 1;
        break;
      end
      step();
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL req_timeout: got imem_req=0 expected 1 within 64 cycles");
    end
  endtask

  task automatic junk(input int n);
    for (int i = 0; i < n; i++) begin
      imem_ack = 1'($urandom);
      inst = $urandom;
      step();
    end
    imem_ack = 1'b0;
  endtask

  task automatic issue(input logic [31:0] w, input int dly);
    bit ok;
    exp_t e;
    wait_req(ok);
    if (!ok) return;
    for (int i = 0; i < dly; i++) begin
      imem_ack = 1'b0;
      inst = $urandom;
      step();
    end
    e = model(w);
    e.ack_cyc = cyc;
    e.req_len = dly + 1;
    q.push_back(e);
    imem_ack = 1'b1;
    inst = w;
    step();
    junk(e.kind == K_RET ? 3 : 12);
  endtask

  function automatic logic [31:0] rand_ok();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 3))
      0: w[6:0] = 7'h33;
      1: begin
        w[6:0] = 7'h13;
        w[14:12] = $urandom_range(0, 1) ? 3'd1 : 3'd5;
      end
      2: w[6:0] = 7'h6F;
      default: w[6:0] = 7'h67;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] rand_bad();
    logic [31:0] w;
    logic [2:0]  f3;
    w = $urandom;
    f3 = 3'($urandom_range(0, 5));
    if (f3 == 3'd1) f3 = 3'd6;
    if (f3 == 3'd5) f3 = 3'd7;
    if ($urandom_range(0, 1) == 1) begin
      w[6:0] = 7'h13;
      w[14:12] = f3;
    end else begin
      w[6:0] = 7'h03;
    end
    return w;
  endfunction

  initial begin
    bit ok;
    rst = 1'b1;
    imem_ack = 1'b0;
    inst = '0;
    step();
    step();
    rst = 1'b0;

    issue(32'h0020_81B3, 0);
    issue(32'h0032_9293, 3);
    issue(32'h0080_00EF, 1);
    for (int i = 0; i < 40; i++) issue(rand_ok(), $urandom_range(0, 3));

    issue(32'h0010_0093, 1);
    do_reset();
    issue(32'h0010_0073, 0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      issue(rand_ok(), $urandom_range(0, 2));
      issue(rand_bad(), $urandom_range(0, 2));
      do_reset();
    end

    // Reset lands on an acked fetch: the word must be dropped.
    issue(rand_ok(), 0);
    wait_req(ok);
    imem_ack = 1'b1;
    inst = 32'h0020_81B3;
    rst = 1'b1;
    step();
    rst = 1'b0;
    imem_ack = 1'b0;
    issue(32'h0080_00EF, 2);

`ifdef EXEC_CTRL_RETIRE_CNT_EN
    wait_req(ok);
    if (ok) begin
      exp_t e;
      e = model(32'h0020_81B3);
      e.ack_cyc = cyc;
      e.req_len = 1;
      q.push_back(e);
      imem_ack = 1'b1;
      inst = 32'h0020_81B3;
      step();
      imem_ack = 1'b0;
      force dut.r_retire_cnt = 32'hFFFF_FFFF;
      mdl_cnt = 32'hFFFF_FFFF;
      step();
      release dut.r_retire_cnt;
      junk(2);
    end
    issue(rand_ok(), 1);
`endif

    for (int i = 0; i < 4; i++) step();
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
